// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ===========================================================================
// Module  : uart_tx_arbiter
// Purpose : Round-robin, packet-locked sharing of a single uart_tx among
//           N_REQ byte-stream requesters.
// Revision: 1.0 - initial release
// ===========================================================================
module uart_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int GAP_TIMEOUT = 1000000
) (
  input  logic               clk_100mhz,
  input  logic               btnc,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               grant_valid,
  output logic [2:0]         grant_id,
  output logic               pkt_done,
  output logic               gap_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic             gv_q,       gv_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             last_q,     last_d;
  logic             pkt_done_q, pkt_done_d;
  logic             gap_err_q,  gap_err_d;
  logic [CNT_W-1:0] gap_cnt_q,  gap_cnt_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [7:0]       owner_byte;

  // Rotating priority scan: rr_ptr, rr_ptr+1, ... wrapping at N_REQ.
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign next_ptr   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
  assign owner_byte = req_data[{owner_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    gv_d       = gv_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    gap_cnt_d  = gap_cnt_q;
    tx_start_d = 1'b0;
    pkt_done_d = 1'b0;
    gap_err_d  = 1'b0;
    req_ready  = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d   = win_idx;
          gv_d      = 1'b1;
          gap_cnt_d = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (req_valid[owner_q]) begin
          // A valid byte while uart_tx is still busy simply waits; the gap
          // timer only measures silence from the owner.
          if (!tx_busy) begin
            req_ready[owner_q] = 1'b1;
            tx_data_d          = owner_byte;
            last_d             = req_last[owner_q];
            tx_start_d         = 1'b1;
            gap_cnt_d          = '0;
            state_d            = WAIT_HI;
          end
        end else if (gap_cnt_q == GAP_MAX) begin
          gap_err_d = 1'b1;
          gv_d      = 1'b0;
          owner_d   = '0;
          rr_ptr_d  = next_ptr;
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end

      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            pkt_done_d = 1'b1;
            gv_d       = 1'b0;
            owner_d    = '0;
            rr_ptr_d   = next_ptr;
            state_d    = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (btnc) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      gv_q       <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      gap_err_q  <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      gv_q       <= gv_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      last_q     <= last_d;
      pkt_done_q <= pkt_done_d;
      gap_err_q  <= gap_err_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_valid = gv_q;
  assign grant_id    = 3'(owner_q);
  assign pkt_done    = pkt_done_q;
  assign gap_err     = gap_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ===========================================================================
// Module  : tb_uart_tx_arbiter
// Purpose : Self-checking bench for uart_tx_arbiter with a packet-level
//           round-robin reference model and a shortened uart_tx model.
// Revision: 1.0 - initial release
// ===========================================================================
module tb_uart_tx_arbiter;

  localparam int N     = 3;
  localparam int GAP   = 16;
  localparam int FRAME = 12;

  logic           clk  = 1'b0;
  logic           btnc = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic           grant_valid;
  logic [2:0]     grant_id;
  logic           pkt_done;
  logic           gap_err;

  uart_tx_arbiter #(.N_REQ(N), .GAP_TIMEOUT(GAP)) dut (
    .clk_100mhz (clk),
    .btnc       (btnc),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .pkt_done   (pkt_done),
    .gap_err    (gap_err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy the cycle after start, for FRAME cycles.
  int u_cnt = 0;
  always @(posedge clk) begin
    if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) tx_busy <= 1'b0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      u_cnt   <= FRAME;
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] qd [N][$];
  bit         ql [N][$];
  bit         en [N];

  logic [7:0] line_q[$];
  int         grants_q[$];
  int         gr_cyc_q[$];
  int         pd_cyc_q[$];
  int         pd_cnt [N];
  int         ready_cnt [N];
  int         start_cnt, gerr_cnt, ge_cyc, ge_fall, fall_cyc, cyc, last_owner;
  logic       ge_gv;
  logic       prev_gv    = 1'b0;
  logic       prev_busy  = 1'b0;
  bit         do_rst_chk = 1'b0;

  logic [7:0] exp_line[$];
  int         exp_grants[$];
  int         exp_pd [N];
  int         mptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && qd[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qd[i][0];
        req_last[i]        = ql[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] ready_s;
    @(negedge clk);
    cyc++;
    ready_s = req_ready;
    if (do_rst_chk) begin
      do_rst_chk = 1'b0;
      chk("rst_tx_data",     32'(tx_data),     32'h0);
      chk("rst_tx_start",    32'(tx_start),    32'h0);
      chk("rst_grant_valid", 32'(grant_valid), 32'h0);
      chk("rst_grant_id",    32'(grant_id),    32'h0);
      chk("rst_pkt_done",    32'(pkt_done),    32'h0);
      chk("rst_gap_err",     32'(gap_err),     32'h0);
      chk("rst_req_ready",   32'(req_ready),   32'h0);
    end
    if (req_ready != '0)
      chk("ready_owner_only", 32'(req_ready), grant_valid ? (32'd1 << grant_id) : 32'd0);
    for (int i = 0; i < N; i++) if (ready_s[i]) ready_cnt[i]++;
    if (tx_start) begin
      line_q.push_back(tx_data);
      start_cnt++;
      chk("start_while_idle_line", 32'(tx_busy), 32'h0);
    end
    if (grant_valid && !prev_gv) begin
      grants_q.push_back(int'(grant_id));
      gr_cyc_q.push_back(cyc);
    end
    if (pkt_done) begin
      chk("pkt_done_after_busy_fall", 32'(tx_busy), 32'h0);
      pd_cnt[last_owner]++;
      pd_cyc_q.push_back(cyc);
    end
    if (gap_err) begin
      gerr_cnt++;
      ge_cyc  = cyc;
      ge_fall = fall_cyc;
      ge_gv   = grant_valid;
    end
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    if (grant_valid) last_owner = int'(grant_id);
    prev_gv   = grant_valid;
    prev_busy = tx_busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ready_s[i] && qd[i].size() > 0) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic reset_dut();
    btnc = 1'b1;
    step();
    btnc       = 1'b0;
    mptr       = 0;
    do_rst_chk = 1'b1;
  endtask

  task automatic clear_mon();
    line_q.delete(); grants_q.delete(); gr_cyc_q.delete(); pd_cyc_q.delete();
    exp_line.delete(); exp_grants.delete();
    for (int i = 0; i < N; i++) begin
      pd_cnt[i] = 0; ready_cnt[i] = 0; exp_pd[i] = 0;
    end
    start_cnt = 0; gerr_cnt = 0; ge_cyc = -1000; ge_fall = 0; ge_gv = 1'bx;
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input bit last);
    qd[i].push_back(d);
    ql[i].push_back(last);
  endtask

  // Packet-level round robin over every queued packet. A packet ends at its
  // last-flagged byte, or is cut short when the requester runs dry.
  task automatic model_run();
    logic [7:0] md [N][$];
    bit         ml [N][$];
    int         w;
    bit         done, lst;
    for (int i = 0; i < N; i++) begin
      md[i] = qd[i];
      ml[i] = ql[i];
    end
    for (int pkt = 0; pkt < 64; pkt++) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && md[(mptr + k) % N].size() > 0) w = (mptr + k) % N;
      if (w < 0) break;
      exp_grants.push_back(w);
      done = 1'b0;
      while (!done && md[w].size() > 0) begin
        exp_line.push_back(md[w].pop_front());
        lst = ml[w].pop_front();
        if (lst) begin
          done = 1'b1;
          exp_pd[w]++;
        end
      end
      mptr = (w + 1) % N;
    end
  endtask

  task automatic run_drain(input string tag);
    int  n;
    bit  empty;
    n = 0;
    do begin
      step();
      n++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (qd[i].size() > 0) empty = 1'b0;
    end while (!(empty && !grant_valid && !tx_busy) && n < 3000);
    chk({tag, "_drain_in_budget"}, 32'(n < 3000), 32'h1);
    step();
    step();
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_line_len"}, 32'(line_q.size()), 32'(exp_line.size()));
    for (int k = 0; k < exp_line.size() && k < line_q.size(); k++)
      chk({tag, "_line_byte"}, 32'(line_q[k]), 32'(exp_line[k]));
    chk({tag, "_grant_cnt"}, 32'(grants_q.size()), 32'(exp_grants.size()));
    for (int k = 0; k < exp_grants.size() && k < grants_q.size(); k++)
      chk({tag, "_grant_id"}, 32'(grants_q[k]), 32'(exp_grants[k]));
    for (int i = 0; i < N; i++)
      chk({tag, "_pkt_done_count"}, 32'(pd_cnt[i]), 32'(exp_pd[i]));
  endtask

  initial begin
    int np, len;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    drive();
    clear_mon();

    // Single requester, three-byte packet
    reset_dut();
    clear_mon();
    push_byte(0, 8'hA5, 1'b0);
    push_byte(0, 8'h3C, 1'b0);
    push_byte(0, 8'h0F, 1'b1);
    model_run();
    drive();
    run_drain("t1");
    chk("t1_starts", 32'(start_cnt), 32'd3);
    chk("t1_byte0", 32'(line_q[0]), 32'hA5);
    chk("t1_byte1", 32'(line_q[1]), 32'h3C);
    chk("t1_byte2", 32'(line_q[2]), 32'h0F);
    chk("t1_ready0_strobes", 32'(ready_cnt[0]), 32'd3);
    chk("t1_pkt_done", 32'(pd_cnt[0]), 32'd1);
    chk("t1_grant_released", 32'(grant_valid), 32'h0);
    compare_model("t1");

    // Two requesters valid right after reset
    reset_dut();
    clear_mon();
    push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h12, 1'b1);
    push_byte(1, 8'h21, 1'b0); push_byte(1, 8'h22, 1'b1);
    model_run();
    drive();
    run_drain("t2");
    chk("t2_first_grant", 32'(grants_q[0]), 32'd0);
    chk("t2_second_grant", 32'(grants_q[1]), 32'd1);
    compare_model("t2");

    // req1 shows up mid-packet of req0
    clear_mon();
    for (int b = 1; b <= 4; b++) push_byte(0, 8'(b), b == 4);
    push_byte(1, 8'h21, 1'b0); push_byte(1, 8'h22, 1'b1);
    model_run();
    en[1] = 1'b0;
    drive();
    for (int n = 0; n < 200 && start_cnt < 2; n++) step();
    chk("t3_reached_second_byte", 32'(start_cnt >= 2), 32'h1);
    en[1] = 1'b1;
    drive();
    run_drain("t3");
    compare_model("t3");
    chk("t3_grant_after_release", 32'(gr_cyc_q[1] - pd_cyc_q[0]), 32'd1);

    // Continuous one-byte packets from two requesters
    clear_mon();
    for (int p = 0; p < 4; p++) begin
      push_byte(0, 8'($urandom), 1'b1);
      push_byte(1, 8'($urandom), 1'b1);
    end
    model_run();
    drive();
    run_drain("t4");
    for (int k = 0; k < 8; k++) chk("t4_alternating_grant", 32'(grants_q[k]), 32'(k % 2));
    chk("t4_req0_packets", 32'(pd_cnt[0]), 32'd4);
    chk("t4_req1_packets", 32'(pd_cnt[1]), 32'd4);
    compare_model("t4");

    // Owner goes silent after a non-last byte
    clear_mon();
    push_byte(0, 8'($urandom), 1'b0);
    push_byte(1, 8'h51, 1'b0); push_byte(1, 8'h52, 1'b1);
    model_run();
    drive();
    run_drain("t5");
    chk("t5_gap_err_count", 32'(gerr_cnt), 32'd1);
    chk("t5_gap_err_timing", 32'(ge_cyc - ge_fall), 32'd17);
    chk("t5_grant_dropped", 32'(ge_gv), 32'h0);
    chk("t5_next_grant_latency", 32'(gr_cyc_q[1] - ge_cyc), 32'd1);
    compare_model("t5");

    // Reset while waiting for the second byte to leave
    clear_mon();
    push_byte(0, 8'h61, 1'b0); push_byte(0, 8'h62, 1'b0); push_byte(0, 8'h63, 1'b1);
    drive();
    for (int n = 0; n < 400 && !(start_cnt == 2 && tx_busy); n++) step();
    step(); step(); step();
    chk("t6_in_second_frame", 32'(start_cnt == 2 && tx_busy), 32'h1);
    qd[0].delete();
    ql[0].delete();
    drive();
    reset_dut();
    clear_mon();
    for (int n = 0; n < 30; n++) step();
    chk("t6_no_start_after_reset", 32'(start_cnt), 32'd0);
    push_byte(1, 8'h71, 1'b0); push_byte(1, 8'h72, 1'b1);
    model_run();
    drive();
    run_drain("t6");
    compare_model("t6");

    // Randomized packet mixes across all requesters
    for (int r = 0; r < 4; r++) begin
      clear_mon();
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
        end
      end
      if (qd[0].size() == 0 && qd[1].size() == 0 && qd[2].size() == 0)
        push_byte(r % N, 8'($urandom), 1'b1);
      model_run();
      drive();
      run_drain("rnd");
      compare_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N_REQ byte-stream requesters, e.g. the solver result dumper and the status/echo responder.
- Grants are round-robin and packet-locked: a granted requester keeps the transmitter until its byte flagged last has fully shifted out.
- Sequences the uart_tx handshake (start pulse, busy wait), so requesters never interleave bytes on the tx line.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- GAP_TIMEOUT, 1000000, max idle cycles between bytes of a granted packet before the grant is revoked (10 ms at 100 MHz).

Ports:
- clk_100mhz  input  1  system clock.
- btnc  input  1  reset; synchronous, active-high.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  byte is the final byte of the packet.
- req_ready  output  N_REQ  combinational one-cycle accept strobe, at most one bit set.
- tx_data  output  8  byte to uart_tx, registered, held until the next load.
- tx_start  output  1  one-cycle start pulse to uart_tx.
- tx_busy  input  1  uart_tx busy; rises 1 cycle after tx_start and falls after the stop bit.
- grant_valid  output  1  a packet is owned.
- grant_id  output  3  index of the owner (0 when no owner).
- pkt_done  output  1  one-cycle pulse when the last byte's transmission completes.
- gap_err  output  1  one-cycle pulse when GAP_TIMEOUT revokes a grant.

Behaviour:
- Reset (btnc high at a clock edge):
  - state=IDLE, rr_ptr=0.
  - tx_data=0, tx_start=0, grant_valid=0, grant_id=0, pkt_done=0, gap_err=0, req_ready=0, gap counter=0.
  - A reset mid-packet abandons the packet. No tx_start is issued after reset; a byte already in flight in uart_tx is not the arbiter's concern.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Next cycle: grant_id=winner, grant_valid=1, state=SEND. No byte is accepted in the arbitration cycle.
- SEND:
  - If req_valid[grant_id] && !tx_busy:
    - req_ready[grant_id]=1 this cycle.
    - Next edge: tx_data<=byte, last_r<=req_last[grant_id], tx_start=1 for exactly one cycle, gap counter cleared, state=WAIT_HI.
  - If req_valid[grant_id]==0: the gap counter increments.
  - When the gap counter reaches GAP_TIMEOUT-1 with valid still low:
    - gap_err pulses, grant_valid=0, rr_ptr=(grant_id+1) mod N_REQ, state=IDLE.
- WAIT_HI: waits for tx_busy=1, then state=WAIT_LO.
- WAIT_LO: waits for tx_busy=0, then:
  - If last_r: pkt_done pulses, grant_valid=0, grant_id=0, rr_ptr=(owner+1) mod N_REQ, state=IDLE.
  - Else: state=SEND.
- Timing:
  - Best case, byte accept to next accept = uart_tx frame time + 3 cycles.
  - Arbitration latency: 1 cycle from valid to grant, +1 cycle to accept.
- Packet lock: requests from non-owners are ignored until release. req_ready for non-owners stays 0.
- Simultaneous events:
  - All requesters valid in IDLE: the rr_ptr scan decides.
  - Owner asserts valid in the same cycle as release: it is re-arbitrated normally. Because rr_ptr has advanced past it, another valid requester wins.
- Single-requester case: an owner with back-to-back packets regains the grant each time, with 1 extra idle cycle.
- req_data/req_last of the owner only need to be stable in the cycle req_valid is high.
- grant_id width is fixed at 3; bits above $clog2(N_REQ) read 0.

Test Plan:
- Reset, then req0 sends 0xA5,0x3C,0x0F (last on 0x0F) with a uart_tx model at 9600 baud:
  - Exactly 3 tx_start pulses; tx_data sequence A5,3C,0F.
  - 3 req_ready[0] strobes.
  - pkt_done once after the final busy fall; grant_valid then 0.
- req0 and req1 both valid in the cycle after reset, each with 2-byte packets (0x11,0x12 / 0x21,0x22):
  - Line order is 11,12,21,22.
  - grant_id goes 0 then 1.
  - req_ready[1] is never set during req0's packet.
- req1 raises valid mid-packet of req0 (packet 0x01..0x04): no 0x2x byte appears before 0x04 completes, and req1 is granted 1 cycle after release.
- Both requesters continuously sending 1-byte packets:
  - Grants alternate 0,1,0,1 over 8 packets.
  - Each requester gets 4 pulses of pkt_done attribution.
- GAP_TIMEOUT=16; req0 sends one non-last byte then drops valid:
  - gap_err pulses exactly 16 cycles after entering SEND with valid low.
  - grant_valid=0, and pending req1 is then granted.
- btnc asserted for 1 cycle during WAIT_LO of a 3-byte packet:
  - Next cycle all outputs are at reset values and no further tx_start occurs.
  - A fresh req1 packet afterwards transmits normally.
